nibble_serial_adder: RTL

- Multi-cycle wide adder that sits directly upstream of the 4-bit ripple adder `fulladd4b` and drives its ports (`a`, `b`, `c_in`, `sum`, `c_out`).
- Accepts W-bit operands through a valid/ready handshake. Feeds them one nibble per cycle, LSB first, into one internal `fulladd4b` instance, with a registered carry between nibbles.
- Assembles the W-bit sum and final carry and presents them through an output valid/ready handshake.
- Trades latency for area: one 4-bit adder serves any operand width.

---
 rtl/nibble_serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: streams operands one nibble per cycle, LSB first, through a
// single 4-bit ripple adder and presents the assembled sum behind a valid/ready handshake.

module fulladd4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] chain;

  always_comb begin
    chain[0] = c_in;
    sum      = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ chain[i];
      chain[i + 1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
    end
    c_out = chain[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [W-1:0]    res;
  logic            carry;
  logic [CW-1:0]   cnt;

  logic [3:0]      nib_sum;
  logic            nib_cout;
  logic [W-1:0]    a_shr;
  logic [W-1:0]    b_shr;
  logic [W-1:0]    res_next;

  fulladd4b u_add (
    .a     (a_sr[3:0]),
    .b     (b_sr[3:0]),
    .c_in  (carry),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // A single nibble has nothing above it to shift in, so that case is special-cased.
  generate
    if (NIBBLES == 1) begin : g_single
      assign a_shr    = '0;
      assign b_shr    = '0;
      assign res_next = nib_sum;
    end else begin : g_multi
      assign a_shr    = {4'b0000, a_sr[W-1:4]};
      assign b_shr    = {4'b0000, b_sr[W-1:4]};
      assign res_next = {nib_sum, res[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          res   <= res_next;
          a_sr  <= a_shr;
          b_sr  <= b_shr;
          carry <= nib_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res;
  assign c_out     = carry;

endmodule
